// File: rtl/addertree_sched.sv
// Two-requester round-robin front end sharing one pipelined adder tree.
// Credit-based issue guarantees every in-flight sum has a result FIFO slot.

module addertree #(
    parameter int Elements = 4,
    parameter int NBitsIn  = 8,
    parameter int NBitsOut = 10,
    parameter int Latency  = 2
) (
    input  logic                                clk,
    input  logic [Elements-1:0][NBitsIn-1:0]    vec,
    output logic signed [NBitsOut-1:0]          sum
);
    localparam int P = 1 << Latency;

    logic signed [NBitsOut-1:0] ext [P];

    // Pad to a power of two so every level is a clean pairwise reduction.
    for (genvar i = 0; i < P; i++) begin : g_ext
        if (i < Elements) begin : g_used
            assign ext[i] = NBitsOut'($signed(vec[i]));
        end else begin : g_pad
            assign ext[i] = '0;
        end
    end

    for (genvar l = 0; l < Latency; l++) begin : g_lvl
        localparam int N = P >> (l + 1);
        logic signed [NBitsOut-1:0] src  [2*N];
        logic signed [NBitsOut-1:0] node [N];
        if (l == 0) begin : g_first
            assign src = ext;
        end else begin : g_next
            assign src = g_lvl[l-1].node;
        end
        always_ff @(posedge clk) begin
            for (int n = 0; n < N; n++) node[n] <= src[2*n] + src[2*n+1];
        end
    end

    assign sum = g_lvl[Latency-1].node[0];
endmodule

module addertree_sched #(
    parameter int Elements  = 4,
    parameter int NBitsIn   = 8,
    parameter int NBitsOut  = 10,
    parameter int FifoDepth = 4
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic [1:0]                          req_valid_in,
    input  logic [Elements-1:0][NBitsIn-1:0]    req0_vec_in,
    input  logic [Elements-1:0][NBitsIn-1:0]    req1_vec_in,
    output logic [1:0]                          req_ready_out,
    output logic                                res_valid_out,
    input  logic                                res_ready_in,
    output logic signed [NBitsOut-1:0]          res_data_out,
    output logic                                res_id_out
);
    localparam int Latency = (Elements == 1) ? 1 : $clog2(Elements);
    localparam int AW      = $clog2(FifoDepth);
    localparam int CW      = AW + 1;

    logic [CW-1:0]   fifo_count, inflight_count;
    logic [CW:0]     used;
    logic            has_credit, any_valid, gid, accept, ptr;
    logic [Latency-1:0] tag_vld, tag_id;
    logic            tag_exit, pop;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [NBitsOut:0] mem [FifoDepth];
    logic [NBitsOut:0] head;
    logic [Elements-1:0][NBitsIn-1:0] tree_in;
    logic signed [NBitsOut-1:0] tree_out;

    // credit > 0  <=>  fifo_count + inflight_count < FifoDepth (registered counts only)
    assign used       = {1'b0, fifo_count} + {1'b0, inflight_count};
    assign has_credit = used < (CW+1)'(FifoDepth);
    assign any_valid  = |req_valid_in;
    assign gid        = (&req_valid_in) ? ptr : req_valid_in[1];

    always_comb begin
        req_ready_out = '0;
        if (!rst_in && any_valid && has_credit) req_ready_out[gid] = 1'b1;
    end

    assign accept  = |req_ready_out;
    assign tree_in = !accept ? '0 : (gid ? req1_vec_in : req0_vec_in);

    addertree #(
        .Elements (Elements),
        .NBitsIn  (NBitsIn),
        .NBitsOut (NBitsOut),
        .Latency  (Latency)
    ) u_tree (
        .clk (clk_in),
        .vec (tree_in),
        .sum (tree_out)
    );

    assign tag_exit = tag_vld[Latency-1];
    assign pop      = res_valid_out & res_ready_in;

    // Tag ids ride alongside the unreset tree data; only the valids need clearing.
    always_ff @(posedge clk_in) begin
        tag_id[0] <= gid;
        for (int k = 1; k < Latency; k++) tag_id[k] <= tag_id[k-1];
    end

    always_ff @(posedge clk_in) begin
        if (tag_exit) mem[wr_ptr] <= {tag_id[Latency-1], tree_out};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tag_vld        <= '0;
            inflight_count <= '0;
            fifo_count     <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            ptr            <= 1'b0;
        end else begin
            tag_vld[0] <= accept;
            for (int k = 1; k < Latency; k++) tag_vld[k] <= tag_vld[k-1];
            if (accept) ptr <= ~gid;
            case ({accept, tag_exit})
                2'b10:   inflight_count <= inflight_count + CW'(1);
                2'b01:   inflight_count <= inflight_count - CW'(1);
                default: inflight_count <= inflight_count;
            endcase
            case ({tag_exit, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (tag_exit) wr_ptr <= wr_ptr + AW'(1);
            if (pop)      rd_ptr <= rd_ptr + AW'(1);
        end
    end

    assign head          = mem[rd_ptr];
    assign res_valid_out = fifo_count != '0;
    assign res_data_out  = res_valid_out ? head[NBitsOut-1:0] : '0;
    assign res_id_out    = res_valid_out & head[NBitsOut];
endmodule

// File: tb/tb_addertree_sched.sv
// Randomized bench for addertree_sched against a queue-based issue/result model.
module tb_addertree_sched;
    localparam int E = 4, NI = 8, NO = 10, FD = 4, LAT = 2;

    logic clk = 1'b0, rst = 1'b0;
    logic [1:0] req_valid = '0, req_ready;
    logic [E-1:0][NI-1:0] v0 = '0, v1 = '0;
    logic res_valid, res_ready = 1'b0, res_id;
    logic signed [NO-1:0] res_data;

    int checks = 0, errors = 0;

    addertree_sched #(.Elements(E), .NBitsIn(NI), .NBitsOut(NO), .FifoDepth(FD)) dut (
        .clk_in(clk), .rst_in(rst), .req_valid_in(req_valid),
        .req0_vec_in(v0), .req1_vec_in(v1), .req_ready_out(req_ready),
        .res_valid_out(res_valid), .res_ready_in(res_ready),
        .res_data_out(res_data), .res_id_out(res_id)
    );

    always #5 clk = ~clk;

    task automatic check(string nm, logic signed [31:0] act, logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Sum of sign-extended elements, wrapped to NO bits.
    function automatic int vsum(logic [E-1:0][NI-1:0] v);
        int s = 0;
        logic signed [NO-1:0] w;
        for (int i = 0; i < E; i++) s += int'($signed(v[i]));
        w = s[NO-1:0];
        return int'(w);
    endfunction

    typedef struct { int data; bit id; int avail; } ent_t;
    ent_t q[$];
    bit   ptr = 1'b0;
    int   ec = 0;
    logic [1:0] exp_ready = '0;
    bit   exp_valid = 1'b0;
    int   gnt_log[$];
    int   pop_data[$];
    int   pop_id[$];

    // Compare process: expected outputs follow from outstanding work and RR pointer.
    always @(negedge clk) begin
        exp_ready = '0;
        exp_valid = 1'b0;
        if (!rst) begin
            if (q.size() < FD && req_valid != 2'b00)
                exp_ready[(req_valid == 2'b11) ? int'(ptr) : int'(req_valid[1])] = 1'b1;
            exp_valid = q.size() > 0 && q[0].avail <= ec;
        end
        check("req_ready", req_ready, exp_ready);
        check("res_valid", res_valid, exp_valid);
        if (exp_valid) begin
            check("res_data", res_data, q[0].data);
            check("res_id", res_id, q[0].id);
        end
        if (rst) begin
            check("rst_data", res_data, 0);
            check("rst_id", res_id, 0);
        end
        if (!rst && (req_ready & req_valid) != 2'b00) gnt_log.push_back(int'(req_ready[1]));
        if (!rst && res_valid && res_ready) begin
            pop_data.push_back(int'(res_data));
            pop_id.push_back(int'(res_id));
        end
    end

    // Model update on the active edge, using the model's own expected handshakes.
    always @(posedge clk) begin
        ec++;
        if (rst) begin
            q.delete();
            ptr = 1'b0;
        end else begin
            if (exp_valid && res_ready) void'(q.pop_front());
            if (exp_ready != 2'b00) begin
                q.push_back('{vsum(exp_ready[1] ? v1 : v0), exp_ready[1], ec + LAT});
                ptr = ~exp_ready[1];
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_vec(output logic [E-1:0][NI-1:0] v, input int a, b, c, d);
        logic [NI-1:0] t[4];
        t[0] = a[NI-1:0]; t[1] = b[NI-1:0]; t[2] = c[NI-1:0]; t[3] = d[NI-1:0];
        for (int i = 0; i < E; i++) v[i] = t[i];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        #1;
        rst = 1'b1;
        req_valid = 2'b11;
        step(2);
        check("reset_ready", req_ready, 0);
        check("reset_valid", res_valid, 0);
        req_valid = 2'b00;
        rst = 1'b0;
        step(1);

        // single issue
        set_vec(v0, 1, 2, 3, 4);
        res_ready = 1'b1;
        req_valid = 2'b01;
        step(1);
        req_valid = 2'b00;
        step(2);
        check("single_valid", res_valid, 1);
        check("single_data", res_data, 10);
        check("single_id", res_id, 0);
        step(2);

        // fairness
        do_reset();
        gnt_log.delete(); pop_id.delete();
        set_vec(v0, 1, 1, 1, 1);
        set_vec(v1, 2, 2, 2, 2);
        req_valid = 2'b11;
        step(8);
        req_valid = 2'b00;
        step(5);
        check("fair_grants", gnt_log.size(), 8);
        for (int k = 0; k < gnt_log.size(); k++) check("fair_grant", gnt_log[k], k % 2);
        check("fair_results", pop_id.size(), 8);
        for (int k = 0; k < pop_id.size(); k++) check("fair_res_id", pop_id[k], k % 2);

        // backpressure
        gnt_log.delete();
        res_ready = 1'b0;
        req_valid = 2'b01;
        step(8);
        check("bp_accepts", gnt_log.size(), 4);
        check("bp_ready_low", req_ready, 0);
        gnt_log.delete();
        res_ready = 1'b1;
        step(1);
        res_ready = 1'b0;
        check("bp_ready_next", req_ready, 1);
        step(4);
        check("bp_one_more", gnt_log.size(), 1);
        req_valid = 2'b00;
        res_ready = 1'b1;
        step(8);

        // signed arithmetic
        pop_data.delete();
        set_vec(v0, -128, -128, -128, -128);
        req_valid = 2'b01;
        step(1);
        set_vec(v0, 127, -1, 0, -126);
        step(1);
        req_valid = 2'b00;
        step(5);
        check("signed_count", pop_data.size(), 2);
        if (pop_data.size() >= 2) begin
            check("signed_min", pop_data[0], -512);
            check("signed_zero", pop_data[1], 0);
        end

        // reset with one FIFO entry held and two in flight
        res_ready = 1'b0;
        set_vec(v0, 1, 1, 1, 1);
        req_valid = 2'b01;
        step(1);
        req_valid = 2'b00;
        step(2);
        req_valid = 2'b01;
        step(2);
        req_valid = 2'b10;
        rst = 1'b1;
        #1;
        check("midrst_valid", res_valid, 0);
        check("midrst_data", res_data, 0);
        check("midrst_id", res_id, 0);
        check("midrst_ready", req_ready, 0);
        step(1);
        rst = 1'b0;
        req_valid = 2'b00;
        res_ready = 1'b1;
        pop_data.delete();
        step(5);
        check("postrst_quiet", pop_data.size(), 0);
        set_vec(v1, 5, 6, 7, 8);
        req_valid = 2'b10;
        step(1);
        req_valid = 2'b00;
        step(2);
        check("postrst_valid", res_valid, 1);
        check("postrst_data", res_data, 26);
        check("postrst_id", res_id, 1);
        step(2);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req_valid = 2'($urandom_range(0, 3));
            for (int i = 0; i < E; i++) begin
                v0[i] = NI'($urandom);
                v1[i] = NI'($urandom);
            end
            res_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 399) == 0);
            step(1);
        end
        rst = 1'b0;
        req_valid = 2'b00;
        res_ready = 1'b1;
        step(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
